seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Multiplexed hex display driver for an N-digit common-anode 7-segment display.
//  Sits directly downstream of the clock divider: its clock port is the divider's
//  buffered slow clock, and every counter here advances once per slow-clock edge.
//  Provides tear-free value updates: writes are staged and committed only at
//  frame boundaries. Also provides optional leading-zero blanking and anti-ghost guard time.
// PARAMETERS
//  NUM_DIGITS    4   digits scanned; value width = 4*NUM_DIGITS; legal range 2..8
//  DWELL_CYCLES  16  slow-clock cycles each digit is selected; must be >= 2
//  GUARD_CYCLES  1   leading cycles of each dwell with all anodes off; 0 <= GUARD < DWELL
// PORTS
//  clock    in   1             slow clock, driven by the divider's clkout
//  reset    in   1             synchronous, active-high
//  load     in   1             single-cycle strobe: stage value/dp_in
//  value    in   4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
//  dp_in    in   NUM_DIGITS    decimal point per digit, 1 = lit
//  blank_lz in   1             1 = blank leading zero digits
//  pending  out  1             staged value not yet committed
//  an       out  NUM_DIGITS    anode selects, active-low
//  seg      out  7             cathodes {g,f,e,d,c,b,a}, active-low
//  dp       out  1             decimal point cathode, active-low
// BEHAVIOUR
//  Reset:
//   - dwell=0, idx=0, disp_val=0, disp_dp=0, stage regs=0, pending=0.
//   - an=all 1, seg=7'h7F, dp=1.
//  Scan:
//   - dwell counts 0..DWELL-1. On wrap, idx advances 0,1,..,NUM_DIGITS-1, then 0.
//   - Frame boundary = cycle where idx==NUM_DIGITS-1 and dwell==DWELL-1.
//  Outputs (all registered, 1-cycle latency from idx/dwell):
//   - an[idx]=0 only when dwell >= GUARD and the digit is not blanked; otherwise an=all 1.
//   - seg = hex decode of disp_val nibble idx; dp = ~disp_dp[idx].
//   - A blanked digit outputs seg=7'h7F, dp=1, an[idx]=1.
//  Load/commit:
//   - load=1: stage <= {value,dp_in}, pending <= 1. A later load overwrites (last write wins).
//   - At a frame boundary with pending=1 (sampled before this cycle's load):
//     disp <= stage, pending <= 0.
//   - load coincident with a boundary: the new data is staged, pending stays 1, and it
//     commits at the next boundary. The old staged data still commits at this boundary
//     if pending was already 1.
//   - The displayed value never changes mid-frame.
//  Leading-zero blanking (evaluated on disp_val, combinational on idx):
//   - Digit i>0 is blanked iff blank_lz=1 and nibbles i..NUM_DIGITS-1 are all 0.
//   - Digit 0 is never blanked. dp_in does not prevent blanking.
//  Decode (active-low):
//   0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//   7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001
//   E=0000110 F=0001110
//  Reset mid-operation: the next edge returns to the reset state; staged data is discarded.
//  Counter widths: $clog2(DWELL_CYCLES) and $clog2(NUM_DIGITS); no overflow states are reachable.
// STRUCTURE
//  Shared package seg7_pkg:
//   - SEG_BLANK = 7'h7F.
//   - 16-entry active-low decode constant table.
//   - Digit-count limits.
//  Sub-module hex_to_seg7 (combinational, 4-bit in, 7-bit out), instantiated once on the
//   selected nibble. Scan counters, staging and blanking logic stay in this module.
// TESTING
//  1. Reset; load 0x1234 -> pending=1 until first boundary, then 0. an low sequence
//     1110,1101,1011,0111; seg 0011001,0110000,0100100,1111001.
//  2. load 0xABCD mid-frame -> an/seg still show the old value through the boundary;
//     the new value appears on the first digit of the next frame.
//  3. Two loads (0x1111, then 0x2222) in one frame -> only 0x2222 is ever displayed.
//  4. blank_lz=1, value 0x0005 -> an[3:1] never low, digit0 shows 0010010.
//     Value 0x0000 -> only digit0 lit, shows 1000000.
//  5. load asserted exactly on the boundary cycle -> commit deferred one full frame;
//     pending stays high across that boundary.
//  6. reset pulsed mid-dwell with pending=1 -> next cycle an=1111, seg=7F, dp=1, pending=0.
//     Display restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
package seg7_pkg;

    // All cathodes off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Supported digit counts
    localparam int unsigned MIN_DIGITS = 2;
    localparam int unsigned MAX_DIGITS = 8;

    // Active-low {g,f,e,d,c,b,a} patterns; entry 15 first so SEG_TABLE[n] decodes nibble n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup on the nibble
    always_comb begin
        seg_c = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit common-anode hex display scanner with frame-synchronous value commit,
// leading-zero blanking and an all-anodes-off guard at the start of each dwell.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,   // 2..8
    parameter int unsigned DWELL_CYCLES = 16,  // >= 2
    parameter int unsigned GUARD_CYCLES = 1    // < DWELL_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic                    pending,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned DW_W  = $clog2(DWELL_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DW_W-1:0]  GUARD_END  = DW_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [DW_W-1:0]       dwell;
    logic [IDX_W-1:0]      idx;
    logic [VAL_W-1:0]      disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [VAL_W-1:0]      stage_val;
    logic [NUM_DIGITS-1:0] stage_dp;

    logic                  boundary_c;
    logic                  guard_done_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic                  above_zero_c;
    logic                  blank_sel_c;
    logic [3:0]            nibble_c;
    logic [6:0]            dec_c;
    logic [NUM_DIGITS-1:0] an_c;
    logic [6:0]            seg_c;
    logic                  dp_c;

    assign boundary_c   = (idx == IDX_LAST) && (dwell == DWELL_LAST);
    assign guard_done_c = (GUARD_CYCLES == 0) ? 1'b1 : (dwell >= GUARD_END);

    // Dwell counter and digit index; idx steps once per completed dwell
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell <= '0;
            idx   <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    // Stage writes; commit the previously staged data only at a frame boundary
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_val <= '0;
            stage_dp  <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
        end else begin
            if (boundary_c && pending) begin
                disp_val <= stage_val;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
            end
            if (load) begin
                stage_val <= value;
                stage_dp  <= dp_in;
                pending   <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and every digit above it are zero
    always_comb begin
        blank_c      = '0;
        above_zero_c = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above_zero_c = above_zero_c & (disp_val[4*i +: 4] == 4'h0);
            blank_c[i]   = blank_lz & above_zero_c;
        end
    end

    assign nibble_c    = disp_val[{idx, 2'b00} +: 4];
    assign blank_sel_c = blank_c[idx];

    hex_to_seg7 u_dec (
        .nibble (nibble_c),
        .seg_c  (dec_c)
    );

    // Next anode/cathode values for the currently selected digit
    always_comb begin
        an_c  = '1;
        seg_c = dec_c;
        dp_c  = ~disp_dp[idx];
        if (blank_sel_c) begin
            seg_c = SEG_BLANK;
            dp_c  = 1'b1;
        end else if (guard_done_c) begin
            an_c[idx] = 1'b0;
        end
    end

    // Registered display pins
    always_ff @(posedge clock) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios plus random traffic,
// compared every cycle against a time-indexed reference model.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int D     = 16;
    localparam int G     = 1;
    localparam int FRAME = N * D;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    // Reference state: position in frame, shown and staged data
    int          mdl_t;
    logic [15:0] mdl_disp;
    logic [3:0]  mdl_disp_dp;
    logic [15:0] mdl_stage;
    logic [3:0]  mdl_stage_dp;
    logic        mdl_pending;

    always #5 clock = ~clock;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (D),
        .GUARD_CYCLES (G)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .pending  (pending),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: ref_seg = 7'b1000000;
            4'h1: ref_seg = 7'b1111001;
            4'h2: ref_seg = 7'b0100100;
            4'h3: ref_seg = 7'b0110000;
            4'h4: ref_seg = 7'b0011001;
            4'h5: ref_seg = 7'b0010010;
            4'h6: ref_seg = 7'b0000010;
            4'h7: ref_seg = 7'b1111000;
            4'h8: ref_seg = 7'b0000000;
            4'h9: ref_seg = 7'b0010000;
            4'hA: ref_seg = 7'b0001000;
            4'hB: ref_seg = 7'b0000011;
            4'hC: ref_seg = 7'b1000110;
            4'hD: ref_seg = 7'b0100001;
            4'hE: ref_seg = 7'b0000110;
            default: ref_seg = 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (frame pos %0d)", tag, obs, exp, mdl_t);
        end
    endtask

    // One clock: drive inputs, predict the registered outputs, check them after the edge
    task automatic step(input logic rst, input logic ld, input logic [15:0] v, input logic [3:0] d);
        logic [3:0]  ea;
        logic [6:0]  es;
        logic        ed;
        logic        ep;
        logic        blank;
        logic [15:0] upper;
        int          digit;
        int          dw;
        reset = rst;
        load  = ld;
        value = v;
        dp_in = d;
        if (rst) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1; ep = 1'b0;
            mdl_t = 0; mdl_disp = '0; mdl_disp_dp = '0;
            mdl_stage = '0; mdl_stage_dp = '0; mdl_pending = 1'b0;
        end else begin
            digit = (mdl_t / D) % N;
            dw    = mdl_t % D;
            upper = mdl_disp >> (4 * digit);
            blank = blank_lz && (digit > 0) && (upper == 16'h0);
            ea = 4'hF;
            if (dw >= G && !blank) ea[digit] = 1'b0;
            es = blank ? 7'h7F : ref_seg(mdl_disp[4*digit +: 4]);
            ed = blank ? 1'b1 : ~mdl_disp_dp[digit];
            if (digit == N - 1 && dw == D - 1 && mdl_pending) begin
                mdl_disp    = mdl_stage;
                mdl_disp_dp = mdl_stage_dp;
                mdl_pending = 1'b0;
            end
            if (ld) begin
                mdl_stage    = v;
                mdl_stage_dp = d;
                mdl_pending  = 1'b1;
            end
            ep    = mdl_pending;
            mdl_t = (mdl_t + 1) % FRAME;
        end
        @(posedge clock);
        #1;
        check("an", 32'(an), 32'(ea));
        check("seg", 32'(seg), 32'(es));
        check("dp", 32'(dp), 32'(ed));
        check("pending", 32'(pending), 32'(ep));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    // Idle until the model's next cycle sits at the given frame position
    task automatic run_to(input int pos);
        while (mdl_t != pos) step(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        dp_in    = '0;
        blank_lz = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);

        // 1: first load commits at the first frame boundary
        step(1'b0, 1'b1, 16'h1234, 4'b0010);
        check("t1_pending", 32'(pending), 32'h1);
        run(2 * FRAME);

        // 2: mid-frame load shows up on digit 0 of the next frame
        run_to(20);
        step(1'b0, 1'b1, 16'hABCD, 4'h0);
        run_to(0);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        check("t2_seg_new", 32'(seg), 32'(7'b0100001));
        run(FRAME + 5);

        // 3: two loads in one frame, last write wins
        run_to(5);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        run(10);
        step(1'b0, 1'b1, 16'h2222, 4'hF);
        run(2 * FRAME);

        // 4: leading-zero blanking
        blank_lz = 1'b1;
        step(1'b0, 1'b1, 16'h0005, 4'h0);
        run(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000, 4'b1111);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // 5: load on the boundary cycle defers the commit one frame
        run_to(FRAME - 1);
        step(1'b0, 1'b1, 16'h5A5A, 4'h3);
        check("t5_pending_held", 32'(pending), 32'h1);
        run(2 * FRAME);

        // 6: reset mid-dwell with data pending
        run_to(37);
        step(1'b0, 1'b1, 16'h9876, 4'h0);
        run(3);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        check("t6_an", 32'(an), 32'hF);
        check("t6_seg", 32'(seg), 32'h7F);
        check("t6_dp", 32'(dp), 32'h1);
        check("t6_pending", 32'(pending), 32'h0);
        run(FRAME + 3);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            logic        r;
            logic        l;
            logic [15:0] v;
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 4));
            step(r, l, v, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
